bridge_sched: RTL and testbench
===============================

BRIDGE_SCHED -- requirements
Module: bridge_sched

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 1000, giving the maximum cycles spent waiting for done after start.
REQ-002 The block SHALL have parameter GAP, default 2, giving the idle cycles inserted between transactions (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports req0 and req1, input, 1 each, held high by requester 0 and requester 1 until granted.
REQ-006 The block SHALL have ports data0 and data1, input, 8 each, the byte offered by each requester, valid while its req is high.
REQ-007 The block SHALL have ports gnt0 and gnt1, output, 1 each, a one-cycle acceptance pulse to the matching requester.
REQ-008 The block SHALL have port start, output, 1, the start strobe to the SPI-to-I2C bridge.
REQ-009 The block SHALL have port data, output, 8, the byte presented to the bridge.
REQ-010 The block SHALL have port done, input, 1, the bridge completion pulse.
REQ-011 The block SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-012 The block SHALL have port cur_id, output, 1, the index of the requester owning the current or most recent transaction.
REQ-013 The block SHALL have port timeout, output, 1, a one-cycle pulse when a transaction is abandoned.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The FSM SHALL have states IDLE, GRANT, START, WAIT and GAP.
REQ-016 IDLE: if req0 or req1 is sampled high, the FSM SHALL select a winner and go to GRANT; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: a lone requester wins, and when both request, the one not equal to last_id wins.
REQ-018 last_id SHALL update to the winner on entry to GRANT.
REQ-019 GRANT, one cycle: the block SHALL assert the winner's gnt, capture the winner's data into data, set cur_id, then go to START.
REQ-020 START, one cycle: the block SHALL drive start=1, then go to WAIT with the wait counter cleared.
REQ-021 Latency: req sampled at edge N SHALL give gnt high in cycle N+1 and start high in cycle N+2.
REQ-022 WAIT: the counter SHALL increment every cycle.
REQ-023 In WAIT, done=1 SHALL move the FSM to GAP.
REQ-024 In WAIT, if the counter reaches TIMEOUT-1 without done, the block SHALL pulse timeout for one cycle and go to GAP.
REQ-025 If done and the timeout condition coincide, done SHALL win and timeout SHALL stay 0.
REQ-026 GAP: the FSM SHALL remain for exactly GAP cycles, then go to IDLE.
REQ-027 req inputs SHALL be ignored outside IDLE.
REQ-028 done SHALL be ignored outside WAIT.
REQ-029 data SHALL hold its captured value from GRANT until the next GRANT and SHALL never change during START, WAIT or GAP.
REQ-030 gnt0 and gnt1 SHALL never be high together.
REQ-031 start SHALL be high for exactly one cycle per transaction.
REQ-032 A requester that drops req before its gnt SHALL lose its slot without error.
REQ-033 Counter width SHALL be clog2(TIMEOUT)+1 bits with no wrap-around before TIMEOUT-1.

Reset
REQ-034 When reset=0, the block SHALL immediately force state=IDLE, start=0, gnt0=gnt1=0, busy=0, timeout=0, data=8'h00, cur_id=0, last_id=1 (requester 0 wins first) and counters=0.
REQ-035 Reset mid-transaction SHALL abandon the transaction with no gnt, start or timeout pulse on release.
REQ-036 After reset deasserts, the first arbitration SHALL occur on the first rising edge at which reset is high.

Verification
REQ-037 Scenario: req0=1, data0=8'hA5, done pulsed 3 cycles after start -> gnt0 in cycle N+1, start with data=A5 in cycle N+2, busy drops 2 cycles after done.
REQ-038 Scenario: req0 and req1 held high continuously, data0=11, data1=22 -> grants alternate 0,1,0,1 and data alternates 11,22.
REQ-039 Scenario: req1=1, done never asserted, TIMEOUT=8 -> timeout pulses exactly 8 cycles after start, then GAP, then IDLE.
REQ-040 Scenario: done asserted in the same cycle the counter reaches TIMEOUT-1 -> no timeout pulse, normal completion.
REQ-041 Scenario: reset asserted in WAIT -> all outputs at reset values in the same cycle; after release with req0 and req1 both high, gnt0 comes first.
REQ-042 Scenario: done pulsed in IDLE and GAP, and req toggled during WAIT -> no state change and no extra gnt.

Source files
------------

// File: rtl/bridge_sched.sv
// bridge_sched: round-robin scheduler feeding an SPI-to-I2C bridge.
// Two requesters compete for the bridge; the winner's byte is latched,
// a start strobe is issued, completion (or timeout) is awaited, and a
// fixed idle gap separates consecutive transactions.
module bridge_sched #(
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned GAP     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       start,
    output logic [7:0] data,
    input  logic       done,
    output logic       busy,
    output logic       cur_id,
    output logic       timeout
);

    localparam int unsigned     CW        = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]   WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [3:0]      GAP_LAST  = 4'(GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_START,
        ST_WAIT,
        ST_GAP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] wcnt, wcnt_n, wcnt_inc;
    logic [3:0]    gcnt, gcnt_n;
    logic          last_id, last_id_n;
    logic          cur_id_n, gnt0_n, gnt1_n, start_n, timeout_n, busy_n;
    logic [7:0]    data_n;
    logic          winner;

    // State, counters and all outputs are registered together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            wcnt    <= '0;
            gcnt    <= '0;
            last_id <= 1'b1;
            cur_id  <= 1'b0;
            data    <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            start   <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            wcnt    <= wcnt_n;
            gcnt    <= gcnt_n;
            last_id <= last_id_n;
            cur_id  <= cur_id_n;
            data    <= data_n;
            gnt0    <= gnt0_n;
            gnt1    <= gnt1_n;
            start   <= start_n;
            timeout <= timeout_n;
            busy    <= busy_n;
        end
    end

    // Next-state logic; outputs are decoded from the state being entered
    // so each registered output lines up with its state.
    always_comb begin
        state_n   = state;
        wcnt_n    = wcnt;
        gcnt_n    = gcnt;
        last_id_n = last_id;
        cur_id_n  = cur_id;
        data_n    = data;
        gnt0_n    = 1'b0;
        gnt1_n    = 1'b0;
        start_n   = 1'b0;
        timeout_n = 1'b0;
        winner    = 1'b0;
        wcnt_inc  = wcnt + 1'b1;

        case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) winner = ~last_id;
                    else              winner = req1;
                    state_n   = ST_GRANT;
                    last_id_n = winner;
                    cur_id_n  = winner;
                    data_n    = winner ? data1 : data0;
                    gnt0_n    = ~winner;
                    gnt1_n    = winner;
                end
            end
            ST_GRANT: begin
                state_n = ST_START;
                start_n = 1'b1;
            end
            ST_START: begin
                state_n = ST_WAIT;
                wcnt_n  = '0;
            end
            ST_WAIT: begin
                // Timeout fires on the edge where the counter lands on
                // TIMEOUT-1, so the pulse coincides with that count; a
                // done sampled on the same edge takes priority.
                wcnt_n = wcnt_inc;
                if (done) begin
                    state_n = ST_GAP;
                    gcnt_n  = '0;
                end else if (wcnt_inc >= WAIT_LAST) begin
                    state_n   = ST_GAP;
                    gcnt_n    = '0;
                    timeout_n = 1'b1;
                end
            end
            ST_GAP: begin
                if (gcnt >= GAP_LAST) begin
                    state_n = ST_IDLE;
                    gcnt_n  = '0;
                end else begin
                    gcnt_n = gcnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_bridge_sched.sv
// Directed bench for bridge_sched (TIMEOUT=8, GAP=2).
module tb_bridge_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, start, busy, cur_id, timeout, done;
    logic [7:0] data;

    int unsigned checks = 0;
    int unsigned passed = 0;

    typedef struct {
        logic       r0;
        logic       r1;
        logic [7:0] d0;
        logic [7:0] d1;
        int         dly;      // cycles after start that done is driven; 0 = never
        logic       id;       // expected winner
        logic [7:0] exp_data;
    } vec_t;

    vec_t vec[8];

    bridge_sched #(.TIMEOUT(8), .GAP(2)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .start(start), .data(data),
        .done(done), .busy(busy),
        .cur_id(cur_id), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt0"}, gnt0, 0);
        chk({tag, "_gnt1"}, gnt1, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_data"}, data, 8'h00);
        chk({tag, "_cur_id"}, cur_id, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int last;
        req0 = v.r0; req1 = v.r1; data0 = v.d0; data1 = v.d1;
        step();
        chk("gnt0", gnt0, !v.id);
        chk("gnt1", gnt1, v.id);
        chk("grant_data", data, v.exp_data);
        chk("cur_id", cur_id, v.id);
        chk("grant_busy", busy, 1);
        req0 = 0; req1 = 0;
        step();
        chk("start", start, 1);
        chk("gnt_clear", gnt0 | gnt1, 0);
        chk("start_data", data, v.exp_data);
        last = (v.dly == 0) ? 7 : v.dly;
        for (int k = 1; k <= last; k++) begin
            step();
            chk("start_once", start, 0);
            chk("no_early_timeout", timeout, 0);
            chk("wait_busy", busy, 1);
            chk("wait_data", data, v.exp_data);
            if (k == v.dly) done = 1;
        end
        step();
        done = 0;
        chk("timeout", timeout, (v.dly == 0));
        chk("gap1_busy", busy, 1);
        step();
        chk("timeout_one_cycle", timeout, 0);
        chk("gap2_busy", busy, 1);
        step();
        chk("idle_busy", busy, 0);
        chk("idle_data", data, v.exp_data);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        vec[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 3, 1'b0, 8'hA5};
        vec[1] = '{1'b0, 1'b1, 8'h00, 8'h3C, 0, 1'b1, 8'h3C};
        vec[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 1, 1'b0, 8'h11};
        vec[3] = '{1'b1, 1'b1, 8'h33, 8'h44, 7, 1'b1, 8'h44};
        vec[4] = '{1'b0, 1'b1, 8'h55, 8'h66, 2, 1'b1, 8'h66};
        vec[5] = '{1'b1, 1'b1, 8'h77, 8'h88, 5, 1'b0, 8'h77};
        vec[6] = '{1'b1, 1'b0, 8'h99, 8'hAA, 0, 1'b0, 8'h99};
        vec[7] = '{1'b1, 1'b1, 8'hBB, 8'hCC, 1, 1'b1, 8'hCC};

        reset = 0; req0 = 0; req1 = 0; data0 = 0; data1 = 0; done = 0;
        step();
        step();
        chk_reset_vals("reset");
        reset = 1;
        step();
        chk_reset_vals("post_reset_idle");

        for (int i = 0; i < 8; i++) run_vec(vec[i]);

        // Both requesters held continuously: grants alternate.
        req0 = 1; req1 = 1; data0 = 8'h11; data1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!(gnt0 || gnt1) && n < 20);
            chk("rr_grant_seen", (n < 20), 1);
            chk("rr_gnt0", gnt0, (i % 2 == 0));
            chk("rr_gnt1", gnt1, (i % 2 == 1));
            chk("rr_data", data, (i % 2 == 0) ? 8'h11 : 8'h22);
            step();
            chk("rr_start", start, 1);
            step();
            done = 1;
            step();
            done = 0;
        end
        req0 = 0; req1 = 0;
        repeat (3) step();
        chk("rr_idle_busy", busy, 0);

        // done in IDLE/GAP and req activity during WAIT are ignored.
        done = 1;
        step();
        done = 0;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_gnt", gnt0 | gnt1 | start, 0);
        step();
        chk("idle_done_busy2", busy, 0);
        req1 = 1; data1 = 8'h6E;
        step();
        chk("ign_gnt1", gnt1, 1);
        req1 = 0;
        step();
        chk("ign_start", start, 1);
        step();
        req0 = 1; req1 = 1; data0 = 8'hEE; data1 = 8'hFF;
        step();
        chk("ign_req_gnt", gnt0 | gnt1, 0);
        chk("ign_req_data", data, 8'h6E);
        req0 = 0; req1 = 0;
        done = 1;
        step();
        done = 1;
        chk("ign_gap_busy", busy, 1);
        step();
        done = 0;
        chk("ign_gap_busy2", busy, 1);
        chk("ign_gap_gnt", gnt0 | gnt1 | start | timeout, 0);
        step();
        chk("ign_idle_busy", busy, 0);
        step();
        chk("ign_no_restart", busy | gnt0 | gnt1, 0);
        chk("ign_data_hold", data, 8'h6E);

        // Asynchronous reset during WAIT, then both request: requester 0 first.
        req1 = 1; data1 = 8'h5A;
        step();
        chk("rst_pre_gnt1", gnt1, 1);
        chk("rst_pre_cur_id", cur_id, 1);
        req1 = 0;
        step();
        step();
        step();
        #2 reset = 0;
        #1 chk_reset_vals("async_reset");
        step();
        chk_reset_vals("reset_hold");
        req0 = 1; req1 = 1; data0 = 8'hC3; data1 = 8'h3C;
        reset = 1;
        step();
        chk("post_rst_gnt0", gnt0, 1);
        chk("post_rst_gnt1", gnt1, 0);
        chk("post_rst_data", data, 8'hC3);
        req0 = 0; req1 = 0;
        step();
        chk("post_rst_start", start, 1);
        step();
        done = 1;
        step();
        done = 0;
        chk("post_rst_no_timeout", timeout, 0);
        repeat (2) step();
        chk("post_rst_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
